// File: rtl/pcie_fifo_rd_sched.sv
// Read-side burst scheduler: waits for a full burst (or a flushed tail) in the
// FIFO, requests a DMA burst, then pops exactly the granted word count.
module pcie_fifo_rd_sched #(
   parameter int DATA_W    = 128,
   parameter int LEVEL_W   = 13,
   parameter int BURST_LEN = 32,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               flush,
   input  logic [LEVEL_W-1:0] fifo_rd_water_level,
   input  logic               fifo_rd_empty,
   output logic               fifo_rd_en,
   input  logic [DATA_W-1:0]  fifo_rd_data,
   output logic               dma_req,
   output logic [LEVEL_W-1:0] dma_len,
   input  logic               dma_ack,
   output logic [DATA_W-1:0]  dma_data,
   output logic               dma_valid,
   output logic               dma_last,
   output logic               busy,
   output logic               flush_done,
   output logic [CNT_W-1:0]   burst_count,
   output logic [1:0]         dbg_state
);

   // Handshake: dma_req holds with a stable dma_len until the first cycle
   // dma_ack is seen high; the data side has no backpressure, so dma_valid
   // simply marks each popped word (gaps allowed) and dma_last the final one.
   typedef enum logic [1:0] {IDLE, REQ, XFER, TAIL} state_t;

   localparam logic [LEVEL_W-1:0] BURST_LV = LEVEL_W'(BURST_LEN);

   state_t             state, state_nxt;
   logic [LEVEL_W-1:0] len, len_nxt;
   logic [LEVEL_W-1:0] remain, remain_nxt;
   logic               flush_pend;
   logic               flush_clr;
   logic               pop;

   always_comb begin
      state_nxt  = state;
      len_nxt    = len;
      remain_nxt = remain;
      pop        = 1'b0;
      flush_clr  = 1'b0;
      case (state)
         IDLE: begin
            if ((enable || flush_pend) && fifo_rd_water_level >= BURST_LV) begin
               len_nxt   = BURST_LV;
               state_nxt = REQ;
            end else if (flush_pend && fifo_rd_water_level != '0) begin
               len_nxt   = fifo_rd_water_level;
               state_nxt = REQ;
            end else if (flush_pend && fifo_rd_empty) begin
               flush_clr = 1'b1;
            end
         end
         REQ: begin
            if (dma_ack) begin
               remain_nxt = len;
               state_nxt  = XFER;
            end
         end
         XFER: begin
            // Empty gating only protects against a lagging level; the counter holds.
            if (!fifo_rd_empty) begin
               pop        = 1'b1;
               remain_nxt = remain - 1'b1;
               if (remain == LEVEL_W'(1)) state_nxt = TAIL;
            end
         end
         TAIL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         len         <= '0;
         remain      <= '0;
         flush_pend  <= 1'b0;
         dma_valid   <= 1'b0;
         dma_last    <= 1'b0;
         burst_count <= '0;
      end else begin
         state      <= state_nxt;
         len        <= len_nxt;
         remain     <= remain_nxt;
         // A new pulse wins over a clear in the same cycle.
         flush_pend <= flush | (flush_pend & ~flush_clr);
         dma_valid  <= pop;
         dma_last   <= pop && (remain == LEVEL_W'(1));
         if (dma_valid && dma_last) burst_count <= burst_count + 1'b1;
      end
   end

   assign fifo_rd_en = pop;
   assign dma_req    = (state == REQ);
   assign dma_len    = len;
   assign dma_data   = fifo_rd_data;
   assign busy       = (state != IDLE);
   assign flush_done = flush_clr;
   assign dbg_state  = state;

endmodule

// File: tb/tb_pcie_fifo_rd_sched.sv
// Bench for pcie_fifo_rd_sched: FIFO model plus a per-cycle reference model
// of the burst rules, with directed scenarios and literal spot checks.
module tb_pcie_fifo_rd_sched;
   localparam int DW = 128;
   localparam int LW = 13;
   localparam int BL = 32;
   localparam int CW = 16;

   logic          clk, rst_n, enable, flush, fifo_rd_empty, dma_ack;
   logic [LW-1:0] fifo_rd_water_level;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_rd_en, dma_req, dma_valid, dma_last, busy, flush_done;
   logic [LW-1:0] dma_len;
   logic [DW-1:0] dma_data;
   logic [CW-1:0] burst_count;
   logic [1:0]    dbg_state;

   pcie_fifo_rd_sched #(.DATA_W(DW), .LEVEL_W(LW), .BURST_LEN(BL), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .fifo_rd_water_level(fifo_rd_water_level), .fifo_rd_empty(fifo_rd_empty),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .dma_req(dma_req), .dma_len(dma_len), .dma_ack(dma_ack),
      .dma_data(dma_data), .dma_valid(dma_valid), .dma_last(dma_last),
      .busy(busy), .flush_done(flush_done), .burst_count(burst_count),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int  word_seq = 0;
   bit  force_empty = 1'b0;
   bit  pop_flag = 1'b0;

   int  n_rd_en = 0, n_valid = 0, n_flush_done = 0, n_req_rise = 0;
   int  ack_cyc = 0, last_cyc = 0, req_cyc = 0;
   int  req_lens[$];
   bit  prev_req = 1'b0;

   // reference model state
   bit  m_req, m_tail, m_flush, m_valid, m_last;
   int  m_left, m_len, m_count;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void fifo_sync();
      fifo_rd_water_level = LW'(fifo_q.size());
      fifo_rd_empty       = (fifo_q.size() == 0) || force_empty;
   endfunction

   task automatic push(input int n);
      logic [31:0] s;
      for (int i = 0; i < n; i++) begin
         s = 32'(word_seq);
         fifo_q.push_back({s, ~s, s ^ 32'h5a5a_a5a5, s + 32'h1000_0000});
         word_seq++;
      end
      fifo_sync();
   endtask

   // One clock: the FIFO model performs the pop the DUT requested at that edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (pop_flag && fifo_q.size() > 0) begin
         fifo_rd_data = fifo_q.pop_front();
         exp_q.push_back(fifo_rd_data);
      end
      pop_flag = 1'b0;
      fifo_sync();
   endtask

   task automatic wait_req(input string name);
      for (int i = 0; i < 40; i++) begin
         if (dma_req) break;
         cycle();
      end
      chk({name, "_req_seen"}, int'(dma_req), 1);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 300; i++) begin
         if (!busy) break;
         cycle();
      end
      chk({name, "_idle"}, int'(busy), 0);
   endtask

   task automatic ack_now();
      dma_ack = 1'b1;
      cycle();
      dma_ack = 1'b0;
   endtask

   task automatic wait_pops(input int base, input int n);
      for (int i = 0; i < 200; i++) begin
         if (n_rd_en - base >= n) break;
         cycle();
      end
      chk("pops_reached", n_rd_en - base, n);
   endtask

   // compare process: mid-cycle, inputs and outputs settled
   always @(negedge clk) begin
      bit e_rd, e_idle, e_fd, nv, nl;
      cyc++;
      if (!rst_n) begin
         chk("rst_rd_en", int'(fifo_rd_en), 0);
         chk("rst_req", int'(dma_req), 0);
         chk("rst_valid", int'(dma_valid), 0);
         chk("rst_last", int'(dma_last), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_flush_done", int'(flush_done), 0);
         chk("rst_len", int'(dma_len), 0);
         chk("rst_count", int'(burst_count), 0);
         chk("rst_state", int'(dbg_state), 0);
         m_req = 0; m_tail = 0; m_flush = 0; m_valid = 0; m_last = 0;
         m_left = 0; m_len = 0; m_count = 0;
         exp_q.delete();
         pop_flag = 1'b0;
         prev_req = 1'b0;
      end else begin
         e_rd   = (m_left > 0) && !fifo_rd_empty;
         e_idle = !m_req && (m_left == 0) && !m_tail;
         e_fd   = e_idle && m_flush && (fifo_rd_water_level == 0) && fifo_rd_empty;
         chk("rd_en", int'(fifo_rd_en), int'(e_rd));
         chk("req", int'(dma_req), int'(m_req));
         chk("len", int'(dma_len), m_len);
         chk("valid", int'(dma_valid), int'(m_valid));
         chk("last", int'(dma_last), int'(m_last));
         chk("busy", int'(busy), int'(!e_idle));
         chk("flush_done", int'(flush_done), int'(e_fd));
         chk("burst_count", int'(burst_count), m_count);
         if (m_valid) begin
            if (exp_q.size() == 0) chk("data_avail", 0, 1);
            else chk_w("dma_data", dma_data, exp_q.pop_front());
         end
         if (fifo_rd_en) n_rd_en++;
         if (dma_valid) n_valid++;
         if (flush_done) n_flush_done++;
         if (dma_req && !prev_req) begin
            n_req_rise++;
            req_cyc = cyc;
            req_lens.push_back(int'(dma_len));
         end
         prev_req = dma_req;
         if (m_req && dma_ack) ack_cyc = cyc;
         if (dma_valid && dma_last) last_cyc = cyc;
         pop_flag = fifo_rd_en;

         nv = e_rd;
         nl = e_rd && (m_left == 1);
         if (m_valid && m_last) m_count = (m_count + 1) % (1 << CW);
         if (m_tail) m_tail = 0;
         else if (m_left > 0) begin
            if (e_rd) begin
               m_left--;
               if (m_left == 0) m_tail = 1;
            end
         end else if (m_req) begin
            if (dma_ack) begin
               m_req  = 0;
               m_left = m_len;
            end
         end else begin
            if ((enable || m_flush) && fifo_rd_water_level >= BL) begin
               m_req = 1; m_len = BL;
            end else if (m_flush && fifo_rd_water_level > 0) begin
               m_req = 1; m_len = int'(fifo_rd_water_level);
            end else if (e_fd) m_flush = 0;
         end
         if (flush) m_flush = 1;
         m_valid = nv;
         m_last  = nl;
      end
   end

   // stimulus
   initial begin
      int r0, v0, a1, bc, fd0, nl0, rr;
      rst_n = 1'b0; enable = 1'b0; flush = 1'b0; dma_ack = 1'b0;
      fifo_rd_data = '0;
      fifo_sync();
      repeat (6) begin
         @(posedge clk); #1;
         enable = 1'($urandom_range(0, 1));
         flush = 1'($urandom_range(0, 1));
         dma_ack = 1'($urandom_range(0, 1));
         fifo_rd_water_level = LW'($urandom_range(0, 100));
         fifo_rd_empty = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      enable = 1'b0; flush = 1'b0; dma_ack = 1'b0;
      fifo_sync();
      rst_n = 1'b1;
      repeat (5) cycle();
      chk("post_reset_busy", int'(busy), 0);

      // full burst, ack three cycles after req, refill during the burst
      enable = 1'b1;
      push(40);
      r0 = n_rd_en; v0 = n_valid;
      wait_req("full");
      chk("full_len", int'(dma_len), 32);
      repeat (3) cycle();
      ack_now();
      push(32);
      wait_idle("full");
      chk("full_pops", n_rd_en - r0, 32);
      chk("full_valids", n_valid - v0, 32);
      chk("full_last_lat", last_cyc - ack_cyc, 33);
      chk("full_count", int'(burst_count), 1);
      a1 = ack_cyc;
      wait_req("second");
      ack_now();
      chk("rereq_gap", req_cyc - a1, 35);
      wait_idle("second");
      chk("second_count", int'(burst_count), 2);

      // below threshold
      push(23);
      chk("below_level", int'(fifo_rd_water_level), 31);
      rr = n_req_rise;
      repeat (100) cycle();
      chk("below_no_req", n_req_rise - rr, 0);

      // flush with enable low: full burst, tail burst, then done
      enable = 1'b0;
      push(14);
      bc = int'(burst_count); fd0 = n_flush_done; nl0 = req_lens.size();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      wait_req("flush_a");
      cycle();
      ack_now();
      wait_idle("flush_a");
      wait_req("flush_b");
      ack_now();
      wait_idle("flush_b");
      for (int i = 0; i < 20; i++) begin
         if (n_flush_done > fd0) break;
         cycle();
      end
      repeat (5) cycle();
      chk("flush_nreq", req_lens.size() - nl0, 2);
      if (req_lens.size() >= nl0 + 2) begin
         chk("flush_len_a", req_lens[nl0], 32);
         chk("flush_len_b", req_lens[nl0+1], 13);
      end
      chk("flush_done_once", n_flush_done - fd0, 1);
      chk("flush_bursts", int'(burst_count) - bc, 2);

      // empty stall mid-transfer
      enable = 1'b1;
      push(32);
      r0 = n_rd_en; v0 = n_valid;
      wait_req("stall");
      ack_now();
      repeat (4) cycle();
      force_empty = 1'b1;
      fifo_sync();
      cycle();
      cycle();
      force_empty = 1'b0;
      fifo_sync();
      wait_idle("stall");
      chk("stall_pops", n_rd_en - r0, 32);
      chk("stall_valids", n_valid - v0, 32);
      chk("stall_last_lat", last_cyc - ack_cyc, 35);

      // enable dropped at pop 10
      bc = int'(burst_count);
      push(32);
      r0 = n_rd_en; v0 = n_valid;
      wait_req("endrop");
      ack_now();
      wait_pops(r0, 10);
      enable = 1'b0;
      wait_idle("endrop");
      chk("endrop_valids", n_valid - v0, 32);
      chk("endrop_count", int'(burst_count) - bc, 1);

      // reset asserted at pop 10
      enable = 1'b1;
      push(32);
      r0 = n_rd_en;
      wait_req("rstmid");
      ack_now();
      wait_pops(r0, 10);
      fd0 = n_flush_done;
      rst_n = 1'b0;
      #1;
      chk("rstmid_rd_en", int'(fifo_rd_en), 0);
      chk("rstmid_busy", int'(busy), 0);
      repeat (2) cycle();
      rst_n = 1'b1;
      rr = n_req_rise;
      repeat (5) cycle();
      chk("rstmid_count", int'(burst_count), 0);
      chk("rstmid_no_fd", n_flush_done - fd0, 0);
      chk("rstmid_level", int'(fifo_rd_water_level), 22);
      chk("rstmid_no_req", n_req_rise - rr, 0);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      wait_req("drain");
      chk("drain_len", int'(dma_len), 22);
      ack_now();
      wait_idle("drain");
      for (int i = 0; i < 20; i++) begin
         if (n_flush_done > fd0) break;
         cycle();
      end
      chk("drain_done", n_flush_done - fd0, 1);
      chk("drain_count", int'(burst_count), 1);
      repeat (3) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pcie_fifo_rd_sched.md
# pcie_fifo_rd_sched

Read-side burst scheduler for `pcie_fifo`, the asynchronous FIFO that stores 16-bit capture data as 128-bit words. The block watches the FIFO read water level and requests a DMA burst from the PCIe DMA engine once a full burst is buffered. After the grant it pops exactly the granted number of words and streams them to the engine with valid/last framing. A latched flush drains any partial tail at end of frame.

## Interface
Parameters:
- `DATA_W`, 128: FIFO read and DMA data width.
- `LEVEL_W`, 13: width of the FIFO read water level (RD_DEPTH_WIDTH+1).
- `BURST_LEN`, 32: full-burst length in words. Legal range is 1 to 4096.
- `CNT_W`, 16: width of the burst counter.

Ports:
- `clk` in 1: single clock; the FIFO read clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: permits full-burst scheduling.
- `flush` in 1: single-cycle pulse requesting a tail drain; latched internally.
- `fifo_rd_water_level` in LEVEL_W: FIFO read-side occupancy in 128-bit words.
- `fifo_rd_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO pop strobe.
- `fifo_rd_data` in DATA_W: FIFO read data, valid 1 cycle after `fifo_rd_en` (no output register).
- `dma_req` out 1: burst request to the DMA engine.
- `dma_len` out LEVEL_W: word count of the requested burst; stable while `dma_req` is high.
- `dma_ack` in 1: grant; taken on the first cycle it is sampled high while `dma_req` is high.
- `dma_data` out DATA_W: equals `fifo_rd_data` (combinational pass-through).
- `dma_valid` out 1: `dma_data` is valid this cycle.
- `dma_last` out 1: final word of the burst; qualified by `dma_valid`.
- `busy` out 1: high whenever the state is not IDLE.
- `flush_done` out 1: 1-cycle pulse when a flush has fully drained.
- `burst_count` out CNT_W: number of completed bursts; wraps modulo 2^CNT_W.

## Operation
States are IDLE, REQ, XFER and TAIL.

IDLE evaluates three conditions in priority order:
1. If (`enable` or `flush_pend`) and level ≥ BURST_LEN: latch `len` = BURST_LEN and go to REQ.
2. Else if `flush_pend` and level > 0: latch `len` = level and go to REQ.
3. Else if `flush_pend` and level = 0 and `fifo_rd_empty`: clear `flush_pend`, pulse `flush_done`, stay in IDLE.

REQ:
- `dma_req` = 1 and `dma_len` = `len`.
- On `dma_ack` = 1, go to XFER. `dma_req` drops in the following cycle.

XFER:
- Assert `fifo_rd_en` when `!fifo_rd_empty`.
- The remaining-word counter decrements once per pop.
- When `fifo_rd_empty` is high, the pop stalls (`fifo_rd_en` = 0) and the counter holds. This produces gaps in `dma_valid`, which the DMA engine must tolerate.
- After the pop that brings the counter to 0, go to TAIL.

TAIL:
- Lasts one cycle while the final word is presented, then returns to IDLE.

Output framing:
- `dma_valid` = `fifo_rd_en` registered one cycle.
- `dma_last` = registered (pop && remaining==1).

Flush handling:
- `flush_pend` is set by a `flush` pulse in any state. A pulse arriving while `flush_pend` is already set has no additional effect.
- When set, `flush_pend` forces full bursts even with `enable` = 0, then triggers a short tail burst, then `flush_done`.

Other rules:
- Deasserting `enable` mid-burst does not abort the burst; only a new request is suppressed.
- `burst_count` increments on every cycle with `dma_valid && dma_last`.
- Bursts shorter than BURST_LEN occur only via flush.
- `fifo_rd_water_level` is conservative (it may lag actual occupancy), so pops covered by the level never underflow. The empty gating is a safeguard only.

## Timing
- Reset (async assert, sync-release safe): state = IDLE. `fifo_rd_en`, `dma_req`, `dma_valid`, `dma_last`, `busy`, `flush_done` and `flush_pend` are all 0. `dma_len` = 0 and `burst_count` = 0. Asserting reset mid-burst abandons the burst immediately; words already popped are lost.
- Level sampled ≥ BURST_LEN in IDLE at cycle N → `dma_req` high at N+1.
- With `dma_ack` sampled at cycle A and no stalls:
  - `fifo_rd_en` is high from A+1 through A+len.
  - `dma_valid` is high from A+2 through A+len+1.
  - `dma_last` is at A+len+1.
  - State returns to IDLE at A+len+2, so the earliest next `dma_req` is at A+len+3.
- Each empty stall adds one cycle to the burst.
- `dma_ack` held high beyond its first cycle is ignored.
- A `flush` pulse in the same cycle as an IDLE evaluation is latched; it takes effect at the next IDLE evaluation.

## Test plan
- **Reset:** `rst_n` = 0 with all inputs toggling → all outputs 0. Release reset with level = 0 → stays IDLE, `busy` = 0.
- **Full burst:** level = 40, `enable` = 1, ack 3 cycles after req → `dma_len` = 32; exactly 32 `fifo_rd_en` and 32 `dma_valid`; `dma_last` on the 32nd; `burst_count` = 1; level-driven second burst not requested until TAIL completes.
- **Below threshold:** level = 31, `enable` = 1 → no `dma_req` for 100 cycles.
- **Flush:** `enable` = 0, level = 45, then a `flush` pulse → one burst with `dma_len` = 32, then a burst with `dma_len` = 13; once the FIFO is empty, `flush_done` pulses once and `burst_count` = 2.
- **Empty stall:** force `fifo_rd_empty` = 1 for 2 cycles mid-XFER → `fifo_rd_en` low for those 2 cycles; still exactly 32 valids; `dma_last` delayed by 2 cycles.
- **Mid-burst events:** `enable` drops at pop 10 → burst completes all 32 words. Reset asserted at pop 10 → outputs 0 in the same cycle, and no `flush_done` or `burst_count` change.
